// File: rtl/line_rotate_scrambler_pkg.sv
// Shared video timing constants and storage types for the cut-and-rotate line scrambler.
package line_rotate_scrambler_pkg;

  localparam int LINE_SIZE_DEF    = 1716;
  localparam int ACTIVE_BYTES_DEF = 1440;
  localparam int CUT_STEP_DEF     = 4;
  localparam int BT656_W          = 10;

  // Stored word layout is {H, V, F, data}; flag bits sit above the video word.
  localparam int FLAG_W    = 3;
  localparam int H_BIT_OFS = 2;
  localparam int V_BIT_OFS = 1;
  localparam int F_BIT_OFS = 0;

  // 12 bits cover both banks (2*1716) and the un-wrapped rotate sum (1439+1020).
  localparam int POS_W = 12;
  localparam int OFF_W = 11;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [OFF_W-1:0] off_t;

endpackage

// File: rtl/line_rotate_scrambler_line_ram.sv
// Simple dual-port line store: one write port, one registered read port (block RAM style).
module line_rotate_scrambler_line_ram
  import line_rotate_scrambler_pkg::*;
#(
  parameter int DEPTH  = 2 * LINE_SIZE_DEF,
  parameter int WIDTH  = BT656_W + FLAG_W,
  parameter int ADDR_W = POS_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/line_rotate_scrambler.sv
// BT.656 cut-and-rotate scrambler: ping-pong line buffer, previous line read back with its
// active region rotated by a per-line offset; timing codes and flags keep a fixed delay.
module line_rotate_scrambler
  import line_rotate_scrambler_pkg::*;
#(
  parameter int LINE_SIZE    = LINE_SIZE_DEF,
  parameter int ACTIVE_BYTES = ACTIVE_BYTES_DEF,
  parameter int CUT_STEP     = CUT_STEP_DEF,
  parameter int DATA_W       = BT656_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] bt_656_in,
  input  logic              H,
  input  logic              V,
  input  logic              F,
  input  logic [7:0]        cut_position,
  input  logic              cut_valid,
  output logic [DATA_W-1:0] bt_656_out,
  output logic              H_out,
  output logic              V_out,
  output logic              F_out,
  output logic              out_valid
);

  localparam int   AS       = LINE_SIZE - ACTIVE_BYTES;
  localparam int   WORD_W   = DATA_W + FLAG_W;
  localparam int   DEPTH    = 2 * LINE_SIZE;
  localparam pos_t LAST_POS = pos_t'(LINE_SIZE - 1);
  localparam pos_t LINE_POS = pos_t'(LINE_SIZE);
  localparam pos_t AS_POS   = pos_t'(AS);
  localparam pos_t ACT_POS  = pos_t'(ACTIVE_BYTES);

  // Write position holds at the last slot so an overlong line overwrites only that entry.
  function automatic pos_t sat_pos(input pos_t p);
    return (p >= LAST_POS) ? LAST_POS : p + pos_t'(1);
  endfunction

  function automatic off_t cut_offset(input logic [7:0] cp);
    return off_t'(cp) * off_t'(CUT_STEP);
  endfunction

  // Offset never exceeds one active width, so a single conditional subtract wraps it.
  function automatic pos_t rot_addr(input pos_t rd_pos, input off_t off);
    pos_t idx;
    if (rd_pos < AS_POS) begin
      return rd_pos;
    end
    idx = (rd_pos - AS_POS) + pos_t'(off);
    if (idx >= ACT_POS) begin
      idx = idx - ACT_POS;
    end
    return AS_POS + idx;
  endfunction

  function automatic pos_t bank_base(input logic bank);
    return bank ? LINE_POS : '0;
  endfunction

  logic              h_q;
  logic              boundary;
  logic              wr_bank_q, wr_bank_d;
  pos_t              wr_pos_q, wr_pos_d, wr_pos_cur;
  logic              primed_q, primed_d;
  off_t              off0_q, off1_q;
  off_t              off_new, rd_off;
  logic              rd_bank;
  pos_t              rd_pos_rot;
  pos_t              waddr, raddr;
  logic [WORD_W-1:0] wdata, rdata;
  logic              vld_p1_q;

  // Boundary sample is already written at position 0 of the freshly selected bank.
  always_comb begin
    boundary   = H & ~h_q;
    wr_bank_d  = boundary ? ~wr_bank_q : wr_bank_q;
    wr_pos_cur = boundary ? '0 : wr_pos_q;
    wr_pos_d   = sat_pos(wr_pos_cur);
    primed_d   = primed_q | (boundary & (wr_pos_q == LAST_POS));
    off_new    = (enable && cut_valid && !V) ? cut_offset(cut_position) : '0;
    rd_bank    = ~wr_bank_d;
    rd_off     = rd_bank ? off1_q : off0_q;
    rd_pos_rot = rot_addr(wr_pos_cur, rd_off);
    waddr      = bank_base(wr_bank_d) + wr_pos_cur;
    raddr      = bank_base(rd_bank) + rd_pos_rot;
    wdata      = {H, V, F, bt_656_in};
  end

  // H history runs through reset so an edge coincident with reset is absorbed, not replayed.
  always_ff @(posedge clk) begin
    h_q <= H;
    if (reset) begin
      wr_pos_q  <= '0;
      wr_bank_q <= 1'b0;
      primed_q  <= 1'b0;
      off0_q    <= '0;
      off1_q    <= '0;
    end else begin
      wr_pos_q  <= wr_pos_d;
      wr_bank_q <= wr_bank_d;
      primed_q  <= primed_d;
      if (boundary) begin
        if (wr_bank_d) begin
          off1_q <= off_new;
        end else begin
          off0_q <= off_new;
        end
      end
    end
  end

  line_rotate_scrambler_line_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (WORD_W),
    .ADDR_W (POS_W)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (~reset),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Stage p1: RAM word available; valid travels alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= primed_d;
    end
  end

  // Stage p2: output register, forced to zero until a full line has been buffered.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      H_out      <= 1'b0;
      V_out      <= 1'b0;
      F_out      <= 1'b0;
      bt_656_out <= '0;
    end else begin
      out_valid <= vld_p1_q;
      if (vld_p1_q) begin
        H_out      <= rdata[DATA_W + H_BIT_OFS];
        V_out      <= rdata[DATA_W + V_BIT_OFS];
        F_out      <= rdata[DATA_W + F_BIT_OFS];
        bt_656_out <= rdata[DATA_W-1:0];
      end else begin
        H_out      <= 1'b0;
        V_out      <= 1'b0;
        F_out      <= 1'b0;
        bt_656_out <= '0;
      end
    end
  end

endmodule
